// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types plus the constants and helpers used by the instruction cache.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_line;

   localparam int OFFSET_WIDTH = 4;

   typedef enum logic [1:0] {
      CS_IDLE,
      CS_FILL,
      CS_FLUSH
   } cache_state_e;

   // Replacement state bits per set: one bit for 2 ways, a 3-node tree for 4 ways.
   function automatic int plru_width(input int ways);
      return (ways == 4) ? 3 : 1;
   endfunction

   function automatic lc3b_word line_word(input lc3b_line line, input logic [2:0] sel);
      return line[{sel, 4'b0000} +: 16];
   endfunction

   function automatic lc3b_word sat_inc(input lc3b_word v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/icache_plru.sv
// Pseudo-LRU replacement for one set: victim from current state, next state after an access.
module icache_plru import lc3b_types::*; #(
   parameter int NUM_WAYS = 2
) (
   input  logic [plru_width(NUM_WAYS)-1:0] state_i,
   input  logic [$clog2(NUM_WAYS)-1:0]     access_way_i,
   output logic [$clog2(NUM_WAYS)-1:0]     victim_o,
   output logic [plru_width(NUM_WAYS)-1:0] state_o
);

   if (NUM_WAYS == 2) begin : g_two
      // The single bit names the way to evict next.
      assign victim_o = state_i;
      assign state_o  = ~access_way_i;
   end else begin : g_tree
      // [0] picks the pair to evict from, [1] picks within ways 0/1, [2] within ways 2/3.
      assign victim_o = state_i[0] ? {1'b1, state_i[2]} : {1'b0, state_i[1]};

      always_comb begin
         state_o    = state_i;
         state_o[0] = ~access_way_i[1];
         if (access_way_i[1]) state_o[2] = ~access_way_i[0];
         else                 state_o[1] = ~access_way_i[0];
      end
   end

endmodule

// File: rtl/i_cache_nway.sv
// N-way set-associative instruction cache: zero-cycle hits, single-line fill, one-cycle flush.
module i_cache_nway import lc3b_types::*; #(
   parameter int NUM_WAYS = 2,
   parameter int NUM_SETS = 8
) (
   input  logic     clk,
   input  logic     reset_n,
   input  lc3b_word mem_address,
   input  logic     mem_read,
   output lc3b_word mem_rdata,
   output logic     mem_resp,
   input  logic     flush,
   output lc3b_word pmem_address,
   output logic     pmem_read,
   input  lc3b_line pmem_rdata,
   input  logic     pmem_resp,
   output lc3b_word hit_count,
   output lc3b_word miss_count
);

   localparam int WAY_W  = $clog2(NUM_WAYS);
   localparam int IDX_W  = $clog2(NUM_SETS);
   localparam int TAG_W  = 16 - OFFSET_WIDTH - IDX_W;
   localparam int PLRU_W = plru_width(NUM_WAYS);

   cache_state_e           state_q;
   logic [15:OFFSET_WIDTH] fill_addr_q;
   logic                   flush_pend_q;
   logic                   pmem_read_q;
   lc3b_word               hit_cnt_q;
   lc3b_word               miss_cnt_q;

   logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q;
   logic [NUM_SETS-1:0][PLRU_W-1:0]   plru_q;
   logic [TAG_W-1:0]                  tag_q  [NUM_SETS][NUM_WAYS];
   lc3b_line                          line_q [NUM_SETS][NUM_WAYS];

   logic [IDX_W-1:0]  req_idx, fill_idx, plru_idx;
   logic [TAG_W-1:0]  req_tag, fill_tag;
   logic [WAY_W-1:0]  hit_way, free_way, plru_victim, victim_way, access_way;
   logic              hit, free_found, rd_hit;
   logic [PLRU_W-1:0] plru_next;
   logic              unused_byte_bit;

   assign req_idx         = mem_address[OFFSET_WIDTH +: IDX_W];
   assign req_tag         = mem_address[15 -: TAG_W];
   assign fill_idx        = fill_addr_q[OFFSET_WIDTH +: IDX_W];
   assign fill_tag        = fill_addr_q[15 -: TAG_W];
   assign unused_byte_bit = mem_address[0];

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   // Descending scan so the lowest-index invalid way wins.
   always_comb begin
      free_found = 1'b0;
      free_way   = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!valid_q[fill_idx][w]) begin
            free_found = 1'b1;
            free_way   = WAY_W'(w);
         end
      end
   end

   assign victim_way = free_found ? free_way : plru_victim;

   // Hits (IDLE) and fills (FILL) never coincide, so one replacement block serves both.
   assign plru_idx   = (state_q == CS_FILL) ? fill_idx : req_idx;
   assign access_way = (state_q == CS_FILL) ? victim_way : hit_way;

   icache_plru #(.NUM_WAYS(NUM_WAYS)) u_plru (
      .state_i      (plru_q[plru_idx]),
      .access_way_i (access_way),
      .victim_o     (plru_victim),
      .state_o      (plru_next)
   );

   assign rd_hit       = (state_q == CS_IDLE) && mem_read && !flush && hit;
   assign mem_resp     = rd_hit;
   assign mem_rdata    = rd_hit ? line_word(line_q[req_idx][hit_way], mem_address[3:1]) : '0;
   assign pmem_read    = pmem_read_q;
   assign pmem_address = {fill_addr_q, {OFFSET_WIDTH{1'b0}}};
   assign hit_count    = hit_cnt_q;
   assign miss_count   = miss_cnt_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= CS_IDLE;
         fill_addr_q  <= '0;
         flush_pend_q <= 1'b0;
         pmem_read_q  <= 1'b0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
         valid_q      <= '0;
         plru_q       <= '0;
      end else begin
         case (state_q)
            CS_IDLE: begin
               if (flush) begin
                  state_q <= CS_FLUSH;
               end else if (mem_read && hit) begin
                  plru_q[req_idx] <= plru_next;
                  hit_cnt_q       <= sat_inc(hit_cnt_q);
               end else if (mem_read) begin
                  fill_addr_q <= mem_address[15:OFFSET_WIDTH];
                  miss_cnt_q  <= sat_inc(miss_cnt_q);
                  pmem_read_q <= 1'b1;
                  state_q     <= CS_FILL;
               end
            end
            CS_FILL: begin
               if (flush) flush_pend_q <= 1'b1;
               if (pmem_resp) begin
                  valid_q[fill_idx][victim_way] <= 1'b1;
                  plru_q[fill_idx]              <= plru_next;
                  flush_pend_q                  <= 1'b0;
                  pmem_read_q                   <= 1'b0;
                  state_q <= (flush_pend_q || flush) ? CS_FLUSH : CS_IDLE;
               end
            end
            CS_FLUSH: begin
               valid_q <= '0;
               plru_q  <= '0;
               state_q <= CS_IDLE;
            end
            default: state_q <= CS_IDLE;
         endcase
      end
   end

   // NOTE: tag and line storage carry no reset; the valid bits alone decide whether a way is live.
   always_ff @(posedge clk) begin
      if ((state_q == CS_FILL) && pmem_resp) begin
         tag_q[fill_idx][victim_way]  <= fill_tag;
         line_q[fill_idx][victim_way] <= pmem_rdata;
      end
   end

endmodule

// File: doc/i_cache_nway.md
I_CACHE_NWAY -- requirements
Module: i_cache_nway

Interface
REQ-001 The module SHALL have parameter NUM_WAYS, default 2, meaning associativity; legal values are 2 and 4.
REQ-002 The module SHALL have parameter NUM_SETS, default 8, meaning set count; legal values are powers of two from 4 to 64.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 mem_address  input  16  byte address of the requested instruction word.
REQ-006 mem_read  input  1  fetch request, held high until mem_resp.
REQ-007 mem_rdata  output  16  selected instruction word.
REQ-008 mem_resp  output  1  single-cycle completion strobe.
REQ-009 flush  input  1  invalidate-all request, one-cycle pulse.
REQ-010 pmem_address  output  16  line-aligned fill address.
REQ-011 pmem_read  output  1  line fill request.
REQ-012 pmem_rdata  input  128  fill line, eight 16-bit words.
REQ-013 pmem_resp  input  1  fill completion strobe.
REQ-014 hit_count  output  16  saturating count of hits.
REQ-015 miss_count  output  16  saturating count of misses.

Function
REQ-016 The address split SHALL be: offset = bits [3:0], word select = bits [3:1], index = next log2(NUM_SETS) bits, tag = the remaining upper bits.
REQ-017 Each set SHALL hold, per way: a valid bit, a tag and a 128-bit line, plus per-set replacement state (1 bit for 2 ways, 3-bit tree-PLRU for 4 ways).
REQ-018 The FSM SHALL have three states: IDLE, FILL and FLUSH.
REQ-019 In IDLE, a read whose tag matches a valid way SHALL assert mem_resp in the same cycle, with mem_rdata = line word[word select]; this zero-cycle hit latency is required.
REQ-020 On a hit, the replacement state SHALL be updated so the hit way is most recently used, and hit_count SHALL increment.
REQ-021 On a miss in IDLE, the FSM SHALL latch mem_address, increment miss_count, and enter FILL next cycle.
REQ-022 In FILL, pmem_read SHALL be high and pmem_address SHALL be {latched address[15:4], 4'b0} until pmem_resp.
REQ-023 Victim selection SHALL pick the lowest-index invalid way, else the PLRU victim.
REQ-024 On pmem_resp, the cache SHALL write line, tag and valid to the victim way, mark that way MRU, and return to IDLE.
REQ-025 mem_resp SHALL NOT be asserted in FILL; the retried request then hits in IDLE one cycle after pmem_resp.
REQ-026 A fill, once started, SHALL complete even if mem_read drops or mem_address changes.
REQ-027 The fill SHALL use only the latched address.
REQ-028 flush in IDLE SHALL enter FLUSH.
REQ-029 FLUSH SHALL clear every valid bit and all replacement state in one cycle, then return to IDLE.
REQ-030 No mem_resp SHALL be asserted in the flush cycle.
REQ-031 flush during FILL SHALL set a pending flag; FLUSH SHALL follow immediately after the fill completes, so the filled line is also invalidated.
REQ-032 If flush and a read arrive in the same IDLE cycle, flush SHALL win: no mem_resp, and no counter change.
REQ-033 Both counters SHALL saturate at 16'hFFFF without wrap.
REQ-034 Outputs SHALL be glitch-free functions of registered state plus current mem_address and mem_read.
REQ-035 No combinational path SHALL exist from pmem_rdata to mem_resp.

Reset
REQ-036 Asserting reset_n low SHALL immediately force: state IDLE, all valid bits 0, replacement state 0, pending-flush 0, mem_resp 0, pmem_read 0, hit_count 0, miss_count 0.
REQ-037 Reset asserted mid-FILL SHALL abandon the fill; pmem_read SHALL drop asynchronously.
REQ-038 Line data and tag arrays SHALL need no reset.

Structure
REQ-039 lc3b_word and lc3b_line SHALL come from the shared lc3b_types package.
REQ-040 A cache state enum and the offset width constant (4) SHALL be added to lc3b_types.
REQ-041 Replacement logic SHALL be a sub-module icache_plru, parametrised on NUM_WAYS, providing victim output and update-on-access.

Verification
REQ-042 Cold miss: reset; read 16'h3006 -> FILL, pmem_address 16'h3000; pmem_resp with line words 0..7 = 16'hA000..A007 -> next cycle mem_resp, mem_rdata 16'hA003, miss_count 1.
REQ-043 Hit: re-read 16'h300E -> same-cycle mem_resp, mem_rdata 16'hA007, hit_count 1.
REQ-044 Eviction, 2 ways, 8 sets: fill 16'h3000, 16'h3080, touch 16'h3000, then miss 16'h3100 -> 16'h3080 evicted; re-read of 16'h3080 misses, 16'h3000 hits.
REQ-045 Four-way PLRU: fill lines at 16'h0000/0080/0100/0180, hit 0000, 0100, then miss 16'h0200 -> victim is the 0080 or 0180 way per the tree state; checked against a reference model.
REQ-046 Flush during FILL: pulse flush mid-fill -> fill completes, FLUSH follows, then re-read of the same address misses again.
REQ-047 Reset mid-FILL and counter saturation: pmem_read drops immediately on reset; after 65536 forced hits, hit_count holds at 16'hFFFF.
